// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared constants and the state type for the LFSR sequencing controller.
package lfsr_seq_ctrl_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DIV_W_DEF = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    LOCK = 2'd3
  } st_e;

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Command/feedback bundle between the sequencing controller and the LFSR register.
interface lfsr_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             lfsr_load;
  logic [WIDTH-1:0] lfsr_seed;
  logic             lfsr_step;
  logic [WIDTH-1:0] lfsr_q;

  modport master (output lfsr_load, lfsr_seed, lfsr_step, input lfsr_q);
  modport slave  (input lfsr_load, lfsr_seed, lfsr_step, output lfsr_q);
endinterface

// File: rtl/lfsr_seq_ctrl_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with level and rising-edge outputs.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1, s2, s2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign level = s2;
  // One cycle per press, however long the button is held.
  assign rise  = s2 & ~s2_d;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencing FSM for the board LFSR: clean load/step commands, auto-step prescaler,
// lock-up detection and period measurement.
//
// state | meaning
// IDLE  | waiting; manual step presses accepted
// LOAD  | one cycle; lfsr_load high, seed captured
// RUN   | auto-stepping every max(period,1) clocks
// LOCK  | all-zero seed/state; only a load leaves
module lfsr_seq_ctrl
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_seed,
  input  logic             btn_load,
  input  logic             btn_step,
  input  logic             run_en,
  input  logic [DIV_W-1:0] period,
  lfsr_seq_ctrl_if.master  lfsr,
  output logic             lock,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len,
  output logic [1:0]       state
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_LOCK = LOCK;

  logic             load_rise, step_rise, run_lvl;
  logic [1:0]       state_nxt;
  logic             load_nxt, step_nxt;
  logic [DIV_W-1:0] presc, presc_nxt, presc_max, presc_term;
  logic [WIDTH-1:0] step_cnt;
  logic             chk, lock_hit, period_hit;

  sync_edge u_sync_load (.clk(clk), .rst_n(rst_n), .din(btn_load), .level(), .rise(load_rise));
  sync_edge u_sync_step (.clk(clk), .rst_n(rst_n), .din(btn_step), .level(), .rise(step_rise));
  sync_edge u_sync_run  (.clk(clk), .rst_n(rst_n), .din(run_en),   .level(run_lvl), .rise());

  assign presc_max  = (period == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : period;
  assign presc_term = presc_max - 1'b1;

  // chk marks the cycle where lfsr_q already reflects the previous step.
  assign lock_hit   = chk && (lfsr.lfsr_q == '0);
  assign period_hit = chk && (state != S_LOAD) && (lfsr.lfsr_q == lfsr.lfsr_seed);

  always_comb begin
    state_nxt = state;
    load_nxt  = 1'b0;
    step_nxt  = 1'b0;
    presc_nxt = '0;
    case (state)
      S_IDLE: begin
        if (load_rise) begin
          state_nxt = S_LOAD;
          load_nxt  = 1'b1;
        end else if (lock_hit) begin
          state_nxt = S_LOCK;
        end else if (run_lvl) begin
          state_nxt = S_RUN;
        end else if (step_rise) begin
          step_nxt = 1'b1;
        end
      end
      S_LOAD: begin
        if (lfsr.lfsr_seed == '0) state_nxt = S_LOCK;
        else if (run_lvl)         state_nxt = S_RUN;
        else                      state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (load_rise) begin
          state_nxt = S_LOAD;
          load_nxt  = 1'b1;
        end else if (lock_hit) begin
          state_nxt = S_LOCK;
        end else if (!run_lvl) begin
          state_nxt = S_IDLE;
        end else if (presc == presc_term) begin
          step_nxt = 1'b1;
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      S_LOCK: begin
        if (load_rise) begin
          state_nxt = S_LOAD;
          load_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      presc          <= '0;
      lfsr.lfsr_load <= 1'b0;
      lfsr.lfsr_step <= 1'b0;
      lfsr.lfsr_seed <= '0;
      lock           <= 1'b0;
      chk            <= 1'b0;
      period_done    <= 1'b0;
      period_len     <= '0;
      step_cnt       <= '0;
    end else begin
      state          <= state_nxt;
      presc          <= presc_nxt;
      lfsr.lfsr_load <= load_nxt;
      lfsr.lfsr_step <= step_nxt;
      lock           <= (state_nxt == S_LOCK);
      chk            <= lfsr.lfsr_step;
      period_done    <= 1'b0;
      if (load_nxt) begin
        lfsr.lfsr_seed <= sw_seed;
        step_cnt       <= '0;
        period_len     <= '0;
      end else if (period_hit) begin
        period_len  <= step_cnt;
        period_done <= 1'b1;
        // A step landing on the hit cycle is the first of the next period.
        step_cnt    <= {{(WIDTH-1){1'b0}}, lfsr.lfsr_step};
      end else if (lfsr.lfsr_step) begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed-plus-random bench for lfsr_seq_ctrl with a behavioural LFSR datapath.
module tb_lfsr_seq_ctrl;

  localparam int W  = 8;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  sw_seed = '0;
  logic          btn_load = 1'b0, btn_step = 1'b0, run_en = 1'b0;
  logic [DW-1:0] period = '0;
  logic          lock, period_done;
  logic [W-1:0]  period_len;
  logic [1:0]    state;
  logic [W-1:0]  dp_q = '0;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int step_q[$];
  int load_q[$];
  int done_q[$];

  lfsr_seq_ctrl_if #(.WIDTH(W)) lfsr_if ();
  assign lfsr_if.lfsr_q = dp_q;

  lfsr_seq_ctrl #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .sw_seed(sw_seed), .btn_load(btn_load),
    .btn_step(btn_step), .run_en(run_en), .period(period), .lfsr(lfsr_if),
    .lock(lock), .period_done(period_done), .period_len(period_len), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] q);
    return {q[0] ^ q[2] ^ q[3] ^ q[4], q[W-1:1]};
  endfunction

  function automatic int lfsr_period(input logic [W-1:0] s);
    logic [W-1:0] q;
    int n;
    q = lfsr_next(s);
    n = 1;
    while (q != s && n < 1000) begin
      q = lfsr_next(q);
      n++;
    end
    return n;
  endfunction

  // Datapath model plus pulse log: each pulse is tagged with the edge that raised it.
  always @(posedge clk) begin
    if (lfsr_if.lfsr_load)      dp_q <= lfsr_if.lfsr_seed;
    else if (lfsr_if.lfsr_step) dp_q <= lfsr_next(dp_q);
    if (lfsr_if.lfsr_step) step_q.push_back(cyc);
    if (lfsr_if.lfsr_load) load_q.push_back(cyc);
    if (period_done)       done_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_load(input int hold);
    btn_load = 1'b1;
    tick(hold);
    btn_load = 1'b0;
  endtask

  initial begin
    int k, s0, l0, d0, exp_len, cnt, bad, t_last, t_next, p, first, r;
    logic [W-1:0] ns;

    // Reset
    #2 rst_n = 1'b0;
    tick(2);
    chk_eq("rst_state", state, 0);
    chk_eq("rst_lock", lock, 0);
    chk_eq("rst_load", lfsr_if.lfsr_load, 0);
    chk_eq("rst_step", lfsr_if.lfsr_step, 0);
    chk_eq("rst_done", period_done, 0);
    chk_eq("rst_seed", lfsr_if.lfsr_seed, 0);
    chk_eq("rst_plen", period_len, 0);
    rst_n = 1'b1;
    tick(2);

    // 1: seed load from IDLE
    sw_seed = 8'h01;
    k  = cyc;
    l0 = load_q.size();
    press_load($urandom_range(1, 6));
    tick(6);
    chk_eq("t1_load_cnt", load_q.size(), l0 + 1);
    chk_eq("t1_load_time", load_q[l0], k + 3);
    chk_eq("t1_seed", lfsr_if.lfsr_seed, 8'h01);
    chk_eq("t1_state", state, 0);
    chk_eq("t1_lock", lock, 0);
    chk_eq("t1_dp_q", dp_q, 8'h01);
    chk_eq("t1_no_step", step_q.size(), 0);

    // 2: full period at one step per clock
    period  = 1;
    exp_len = lfsr_period(8'h01);
    k  = cyc;
    s0 = step_q.size();
    d0 = done_q.size();
    run_en = 1'b1;
    for (int i = 0; i < 700 && done_q.size() == d0; i++) tick();
    chk_eq("t2_done_seen", done_q.size() > d0, 1);
    chk_eq("t2_first_step", step_q[s0], k + 4);
    chk_eq("t2_done_time", done_q[d0], k + 5 + exp_len);
    cnt = 0;
    for (int i = s0; i < step_q.size(); i++) if (step_q[i] <= done_q[d0] - 2) cnt++;
    chk_eq("t2_step_count", cnt, exp_len);
    chk_eq("t2_period_len", period_len, exp_len & 'hFF);
    run_en = 1'b0;
    tick(6);
    chk_eq("t2_idle", state, 0);

    // 3: zero seed locks; only a nonzero load escapes
    sw_seed = 8'h00;
    press_load($urandom_range(1, 4));
    tick(6);
    chk_eq("t3_state", state, 3);
    chk_eq("t3_lock", lock, 1);
    s0 = step_q.size();
    btn_step = 1'b1;
    tick(3);
    btn_step = 1'b0;
    run_en = 1'b1;
    tick(12);
    run_en = 1'b0;
    tick(4);
    chk_eq("t3_no_steps", step_q.size(), s0);
    chk_eq("t3_still_lock", state, 3);
    sw_seed = 8'h5A;
    press_load(2);
    tick(6);
    chk_eq("t3_exit_state", state, 0);
    chk_eq("t3_exit_lock", lock, 0);
    chk_eq("t3_exit_seed", lfsr_if.lfsr_seed, 8'h5A);
    chk_eq("t3_exit_dp_q", dp_q, 8'h5A);

    // 4: period 4 spacing, then a load landing exactly on prescaler expiry
    period = 4;
    k  = cyc;
    s0 = step_q.size();
    run_en = 1'b1;
    for (int i = 0; i < 100 && step_q.size() < s0 + 3; i++) tick();
    chk_eq("t4_first_step", step_q[s0], k + 3 + 4);
    bad = 0;
    for (int i = s0 + 1; i < step_q.size(); i++) if (step_q[i] - step_q[i-1] != 4) bad++;
    chk_eq("t4_gaps", bad, 0);
    s0 = step_q.size();
    for (int i = 0; i < 20 && step_q.size() == s0; i++) tick();
    t_last = step_q[$];
    t_next = t_last + 4;
    ns = 8'($urandom_range(1, 255));
    sw_seed = ns;
    l0 = load_q.size();
    s0 = step_q.size();
    press_load(1);
    tick(12);
    chk_eq("t4_load_time", load_q[l0], t_next);
    bad = 0;
    for (int i = s0; i < step_q.size(); i++) if (step_q[i] == t_next) bad++;
    chk_eq("t4_no_step_on_load", bad, 0);
    chk_eq("t4_resume_step", step_q[s0], t_next + 1 + 4);
    chk_eq("t4_seed", lfsr_if.lfsr_seed, ns);

    // 5: held step button in IDLE gives one step; in RUN gives none extra
    run_en = 1'b0;
    tick(6);
    k  = cyc;
    s0 = step_q.size();
    btn_step = 1'b1;
    tick(20);
    btn_step = 1'b0;
    tick(4);
    chk_eq("t5_idle_count", step_q.size(), s0 + 1);
    chk_eq("t5_idle_time", step_q[s0], k + 3);
    p = $urandom_range(3, 6);
    period = DW'(p);
    k  = cyc;
    s0 = step_q.size();
    run_en = 1'b1;
    tick(p + 8);
    btn_step = 1'b1;
    tick(20);
    btn_step = 1'b0;
    tick(p * 3);
    first = k + 3 + p;
    chk_eq("t5_run_first", step_q[s0], first);
    chk_eq("t5_run_count", step_q.size() - s0, ((cyc - 1) - first) / p + 1);
    bad = 0;
    for (int i = s0 + 1; i < step_q.size(); i++) if (step_q[i] - step_q[i-1] != p) bad++;
    chk_eq("t5_run_gaps", bad, 0);

    // 6: reset mid-RUN with period 0
    run_en = 1'b0;
    tick(4);
    period = '0;
    run_en = 1'b1;
    tick(10);
    rst_n = 1'b0;
    #1;
    chk_eq("t6_step", lfsr_if.lfsr_step, 0);
    chk_eq("t6_load", lfsr_if.lfsr_load, 0);
    chk_eq("t6_lock", lock, 0);
    chk_eq("t6_done", period_done, 0);
    chk_eq("t6_plen", period_len, 0);
    chk_eq("t6_seed", lfsr_if.lfsr_seed, 0);
    chk_eq("t6_state", state, 0);
    tick(2);
    rst_n = 1'b1;
    r  = cyc;
    s0 = step_q.size();
    tick(2);
    chk_eq("t6_post_state", state, 0);
    chk_eq("t6_post_nostep", step_q.size(), s0);
    tick(8);
    chk_eq("t6_first_step", step_q[s0], r + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
